regfile_wb_unit: RTL

REGFILE_WB_UNIT -- requirements
Module: regfile_wb_unit

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and widths, plus helpers that size write-buffer
// pointers and counters from a buffer depth.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   // A one-entry buffer still needs a one-bit pointer.
   function automatic int ptr_w(input int depth);
      if (depth > 1) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback buffer: storage, wrapping pointers and occupancy count.
// Presents its contents oldest-first so callers can scan entries by age.
module wb_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   output logic             full,
   output wb_entry_t        aged       [DEPTH],
   output logic [DEPTH-1:0] aged_valid
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   wb_entry_t     mem_r [DEPTH];
   logic          do_push_s;
   logic          do_pop_s;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return {AW{1'b0}};
      end else begin
         return p + AW'(1);
      end
   endfunction

   assign full      = (count_r == CW'(DEPTH));
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && (count_r != {CW{1'b0}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Payload storage needs no reset: unoccupied slots are masked by aged_valid.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   always_comb begin
      aged       = '{default: '0};
      aged_valid = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         aged[i]       = mem_r[AW'((int'(rd_ptr_r) + i) % DEPTH)];
         aged_valid[i] = (CW'(i) < count_r);
      end
   end

endmodule

// File: rtl/regfile_wb_unit.sv
// Writeback buffer between MEM and the register-file write port, with
// decode-stage hazard lookup. Define WB_FWD_EN to forward pending data.
module regfile_wb_unit
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [XLEN-1:0]       in_data,
   output logic                  wen,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [XLEN-1:0]       rd_v,
   input  logic                  wr_grant,
   input  logic [REG_ADDR_W-1:0] rs1_q,
   input  logic [REG_ADDR_W-1:0] rs2_q,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic [XLEN-1:0]       rs1_fwd_v,
   output logic [XLEN-1:0]       rs2_fwd_v
);

   logic             full_s;
   logic             push_s;
   logic             pop_s;
   wb_entry_t        push_entry_s;
   wb_entry_t        aged_s [DEPTH];
   logic [DEPTH-1:0] aged_valid_s;
   logic [DEPTH-1:0] rs1_match_s;
   logic [DEPTH-1:0] rs2_match_s;

   // x0 writebacks are handshaken normally but never stored.
   assign in_ready     = !full_s;
   assign push_s       = in_valid && in_ready && (in_rd != {REG_ADDR_W{1'b0}});
   assign push_entry_s = '{rd: in_rd, data: in_data};
   assign pop_s        = wen && wr_grant;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .full       (full_s),
      .aged       (aged_s),
      .aged_valid (aged_valid_s)
   );

   assign wen  = aged_valid_s[0];
   assign rd   = aged_valid_s[0] ? aged_s[0].rd   : {REG_ADDR_W{1'b0}};
   assign rd_v = aged_valid_s[0] ? aged_s[0].data : {XLEN{1'b0}};

   // An entry being popped this cycle is still pending, since state is registered.
   always_comb begin
      rs1_match_s = {DEPTH{1'b0}};
      rs2_match_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         rs1_match_s[i] = aged_valid_s[i] && (aged_s[i].rd == rs1_q)
                          && (rs1_q != {REG_ADDR_W{1'b0}});
         rs2_match_s[i] = aged_valid_s[i] && (aged_s[i].rd == rs2_q)
                          && (rs2_q != {REG_ADDR_W{1'b0}});
      end
   end

   assign rs1_busy = |rs1_match_s;
   assign rs2_busy = |rs2_match_s;

`ifdef WB_FWD_EN
   // Scan oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      rs1_fwd_v = {XLEN{1'b0}};
      rs2_fwd_v = {XLEN{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (rs1_match_s[i]) begin
            rs1_fwd_v = aged_s[i].data;
         end else begin
            rs1_fwd_v = rs1_fwd_v;
         end
         if (rs2_match_s[i]) begin
            rs2_fwd_v = aged_s[i].data;
         end else begin
            rs2_fwd_v = rs2_fwd_v;
         end
      end
   end
`else
   assign rs1_fwd_v = {XLEN{1'b0}};
   assign rs2_fwd_v = {XLEN{1'b0}};
`endif

endmodule
